// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator sequencer: key codes, operator
// encodings, the LCD "show result" symbol and the sequencer state enum.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  localparam logic [3:0] LCD_SHOW_RESULT = 4'd15;

  localparam logic [1:0] SEL_ADD = 2'd0;
  localparam logic [1:0] SEL_SUB = 2'd1;
  localparam logic [1:0] SEL_MUL = 2'd2;
  localparam logic [1:0] SEL_DIV = 2'd3;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_EXEC = 3'd2,
    S_SHOW = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  function automatic logic is_digit(input logic [3:0] c);
    return (c <= 4'd9);
  endfunction

  function automatic logic is_op(input logic [3:0] c);
    return (c >= KEY_ADD) && (c <= KEY_DIV);
  endfunction

  // Operator keys are contiguous, so the math select is just the offset from "+".
  function automatic logic [1:0] op_sel(input logic [3:0] c);
    return 2'(c - KEY_ADD);
  endfunction

endpackage

// File: rtl/bcd_shift_reg.sv
// Four-digit BCD operand register: digits shift in from the right, with a
// parallel load (results, fresh single digit) and a clear. Clear beats load beats shift.
module bcd_shift_reg (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic [15:0] load_val_i,
  input  logic        shift_i,
  input  logic [3:0]  digit_i,
  output logic [15:0] q_o
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = load_val_i;
    end else if (shift_i) begin
      q_d = {q_q[11:0], digit_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: builds BCD operands from key events, launches the
// math unit with a timeout watchdog and issues one LCD write per key or result.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int ALU_TIMEOUT = 1024
) (
  input  logic        CLOCK_50,
  input  logic        RST,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        key_ready,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [1:0]  math_sel,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] result_bcd,
  output logic        lcd_req,
  output logic [3:0]  lcd_code,
  input  logic        lcd_ack,
  output logic        err,
  output state_t      dbg_state
);

  localparam int CW = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic          err_q, err_d;
  logic          start_q, start_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lcd_req_q, lcd_req_d;
  logic [3:0]    lcd_code_q, lcd_code_d;

  logic          key_accept;
  logic          a_clr, a_load, a_shift, b_clr, b_shift;
  logic [15:0]   a_load_val;
  logic          lcd_post;
  logic [3:0]    lcd_sym;

  // Key handshake: an event transfers on a cycle with key_valid && key_ready;
  // key_ready is withheld while an LCD write is outstanding or the math unit runs.
  assign key_ready = !lcd_req_q &&
                     ((state_q == S_A) || (state_q == S_B) ||
                      (state_q == S_DONE) || (state_q == S_ERR));
  assign key_accept = key_valid && key_ready;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    err_d      = err_q;
    start_d    = 1'b0;
    cnt_d      = cnt_q;
    lcd_req_d  = lcd_req_q;
    lcd_code_d = lcd_code_q;
    a_clr      = 1'b0;
    a_load     = 1'b0;
    a_load_val = result_bcd;
    a_shift    = 1'b0;
    b_clr      = 1'b0;
    b_shift    = 1'b0;
    lcd_post   = 1'b0;
    lcd_sym    = key_code;

    if (lcd_req_q && lcd_ack) lcd_req_d = 1'b0;

    if (key_accept) begin
      if (key_code == KEY_CLR) begin
        a_clr    = 1'b1;
        b_clr    = 1'b1;
        sel_d    = SEL_ADD;
        err_d    = 1'b0;
        state_d  = S_A;
        lcd_post = 1'b1;
        lcd_sym  = LCD_SHOW_RESULT;
      end else begin
        case (state_q)
          S_A: begin
            if (is_digit(key_code)) begin
              a_shift  = 1'b1;
              lcd_post = 1'b1;
            end else if (is_op(key_code)) begin
              sel_d    = op_sel(key_code);
              b_clr    = 1'b1;
              state_d  = S_B;
              lcd_post = 1'b1;
            end
          end
          S_B: begin
            if (is_digit(key_code)) begin
              b_shift  = 1'b1;
              lcd_post = 1'b1;
            end else if (is_op(key_code)) begin
              sel_d    = op_sel(key_code);
              lcd_post = 1'b1;
            end else if ((sel_q == SEL_DIV) && (op_b == 16'h0000)) begin
              err_d    = 1'b1;
              state_d  = S_ERR;
              lcd_post = 1'b1;
              lcd_sym  = LCD_SHOW_RESULT;
            end else begin
              state_d = S_EXEC;
              start_d = 1'b1;
              cnt_d   = '0;
            end
          end
          S_DONE: begin
            // A digit starts a fresh calculation; an operator chains on the result.
            if (is_digit(key_code)) begin
              a_load     = 1'b1;
              a_load_val = {12'h000, key_code};
              b_clr      = 1'b1;
              state_d    = S_A;
              lcd_post   = 1'b1;
            end else if (is_op(key_code)) begin
              sel_d    = op_sel(key_code);
              b_clr    = 1'b1;
              state_d  = S_B;
              lcd_post = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    case (state_q)
      S_EXEC: begin
        if (alu_done) begin
          a_load     = 1'b1;
          a_load_val = result_bcd;
          state_d    = S_SHOW;
          lcd_post   = 1'b1;
          lcd_sym    = LCD_SHOW_RESULT;
        end else if (cnt_q == CNT_LAST) begin
          err_d    = 1'b1;
          state_d  = S_ERR;
          lcd_post = 1'b1;
          lcd_sym  = LCD_SHOW_RESULT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHOW: begin
        if (lcd_req_q && lcd_ack) state_d = S_DONE;
      end
      default: ;
    endcase

    if (lcd_post) begin
      lcd_req_d  = 1'b1;
      lcd_code_d = lcd_sym;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q    <= S_A;
      sel_q      <= SEL_ADD;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      cnt_q      <= '0;
      lcd_req_q  <= 1'b0;
      lcd_code_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
      start_q    <= start_d;
      cnt_q      <= cnt_d;
      lcd_req_q  <= lcd_req_d;
      lcd_code_q <= lcd_code_d;
    end
  end

  bcd_shift_reg u_op_a (
    .clk_i      (CLOCK_50),
    .rst_i      (RST),
    .clr_i      (a_clr),
    .load_i     (a_load),
    .load_val_i (a_load_val),
    .shift_i    (a_shift),
    .digit_i    (key_code),
    .q_o        (op_a)
  );

  bcd_shift_reg u_op_b (
    .clk_i      (CLOCK_50),
    .rst_i      (RST),
    .clr_i      (b_clr),
    .load_i     (1'b0),
    .load_val_i (16'h0000),
    .shift_i    (b_shift),
    .digit_i    (key_code),
    .q_o        (op_b)
  );

  assign math_sel  = sel_q;
  assign alu_start = start_q;
  assign lcd_req   = lcd_req_q;
  assign lcd_code  = lcd_code_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios plus a randomized key stream,
// all checked against a decimal-arithmetic model of the calculator.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        key_ready;
  logic [15:0] op_a, op_b;
  logic [1:0]  math_sel;
  logic        alu_start;
  logic        alu_done = 1'b0;
  logic [15:0] result_bcd = 16'h0000;
  logic        lcd_req;
  logic [3:0]  lcd_code;
  logic        lcd_ack = 1'b0;
  logic        err;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  bit pend_drop = 0;

  // Model: operands as plain decimal numbers, expected LCD symbols in a queue.
  int         m_a, m_b, m_sel, m_err;
  state_t     m_mode;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  calc_sequencer #(.ALU_TIMEOUT(TO)) dut (
    .CLOCK_50(clk), .RST(rst), .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .op_a(op_a), .op_b(op_b), .math_sel(math_sel),
    .alu_start(alu_start), .alu_done(alu_done), .result_bcd(result_bcd),
    .lcd_req(lcd_req), .lcd_code(lcd_code), .lcd_ack(lcd_ack), .err(err),
    .dbg_state(dbg_state)
  );

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_sel = 0; m_err = 0; m_mode = S_A;
    exp_q.delete();
  endtask

  task automatic model_key(input logic [3:0] code, output bit req);
    int c;
    c = int'(code);
    req = 1'b0;
    if (c == 15) begin
      m_a = 0; m_b = 0; m_sel = 0; m_err = 0; m_mode = S_A; req = 1'b1;
    end else if (m_mode == S_A) begin
      if (c < 10) begin m_a = (m_a * 10 + c) % 10000; req = 1'b1; end
      else if (c < 14) begin m_sel = c - 10; m_b = 0; m_mode = S_B; req = 1'b1; end
    end else if (m_mode == S_B) begin
      if (c < 10) begin m_b = (m_b * 10 + c) % 10000; req = 1'b1; end
      else if (c < 14) begin m_sel = c - 10; req = 1'b1; end
      else if (m_sel == 3 && m_b == 0) begin m_err = 1; m_mode = S_ERR; req = 1'b1; end
      else m_mode = S_EXEC;
    end else if (m_mode == S_DONE) begin
      if (c < 10) begin m_a = c; m_b = 0; m_mode = S_A; req = 1'b1; end
      else if (c < 14) begin m_sel = c - 10; m_b = 0; m_mode = S_B; req = 1'b1; end
    end
    if (req) exp_q.push_back((c == 14) ? 4'd15 : code);
  endtask

  task automatic model_result(input int r);
    m_a = r; m_mode = S_SHOW; exp_q.push_back(4'd15);
  endtask

  task automatic model_timeout();
    m_err = 1; m_mode = S_ERR; exp_q.push_back(4'd15);
  endtask

  // LCD scoreboard: every accepted write must match the next expected symbol,
  // and the request must be gone the cycle after the acknowledge.
  always @(negedge clk) begin
    if (alu_start === 1'b1) start_cnt++;
    if (rst) begin
      pend_drop = 0;
    end else begin
      if (pend_drop) begin
        checks++;
        if (lcd_req !== 1'b0) begin
          errors++; $display("FAIL lcd_drop got=%b want=0", lcd_req);
        end
        pend_drop = 0;
      end
      if (lcd_req === 1'b1 && lcd_ack === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL lcd_unexpected got=%0d want=none", lcd_code);
        end else if (lcd_code !== exp_q[0]) begin
          errors++; $display("FAIL lcd_code got=%0d want=%0d", lcd_code, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
        pend_drop = 1;
      end
    end
  end

  // Drivers
  task automatic press_key(input logic [3:0] code, output bit got_req, output bit exp_req);
    int n;
    n = 0;
    got_req = 1'b0;
    exp_req = 1'b0;
    while (key_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (key_ready !== 1'b1) begin
      errors++; $display("FAIL key_ready_wait got=%b want=1", key_ready);
      return;
    end
    key_valid = 1'b1; key_code = code;
    @(posedge clk); #1;
    key_valid = 1'b0;
    model_key(code, exp_req);
    got_req = (lcd_req === 1'b1);
    if (got_req) begin
      lcd_ack = 1'b1; @(posedge clk); #1; lcd_ack = 1'b0;
    end
  endtask

  task automatic run_alu(input int d, input logic [15:0] res);
    repeat (d) begin @(posedge clk); #1; end
    alu_done = 1'b1; result_bcd = res;
    @(posedge clk); #1;
    alu_done = 1'b0; result_bcd = 16'($urandom);
  endtask

  task automatic ack_lcd();
    lcd_ack = 1'b1; @(posedge clk); #1; lcd_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; repeat (2) @(posedge clk); #1; rst = 1'b0;
    model_reset();
  endtask

  // Scenarios
  task automatic test_reset();
    do_reset();
    checks++;
    if ({key_ready, op_a, op_b, math_sel, alu_start, lcd_req, lcd_code, err} !==
        {1'b1, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL reset_vals got=%h want=%h",
        {key_ready, op_a, op_b, math_sel, alu_start, lcd_req, lcd_code, err}, 42'h200_0000_0000);
    end
    checks++;
    if (dbg_state !== S_A) begin errors++; $display("FAIL reset_state got=%0d want=%0d", dbg_state, S_A); end
  endtask

  task automatic test_add();
    logic [3:0] keys[5] = '{4'd1, 4'd2, KEY_ADD, 4'd3, 4'd4};
    bit g, e;
    foreach (keys[i]) begin
      press_key(keys[i], g, e);
      checks++;
      if (g !== 1'b1) begin errors++; $display("FAIL add_key_lcd idx=%0d got=%b want=1", i, g); end
    end
    checks++;
    if ({op_a, op_b, math_sel} !== {16'h0012, 16'h0034, SEL_ADD}) begin
      errors++; $display("FAIL add_operands got=%h/%h/%0d want=0012/0034/0", op_a, op_b, math_sel);
    end
    press_key(KEY_EQ, g, e);
    checks++;
    if ({alu_start, g} !== 2'b10) begin errors++; $display("FAIL add_start got=%b want=10", {alu_start, g}); end
    @(posedge clk); #1;
    checks++;
    if (alu_start !== 1'b0) begin errors++; $display("FAIL add_start_pulse got=%b want=0", alu_start); end
    run_alu(1, 16'h0046);
    model_result(46);
    checks++;
    if ({op_a, lcd_req, lcd_code} !== {16'h0046, 1'b1, 4'd15}) begin
      errors++; $display("FAIL add_result got=%h/%b/%0d want=0046/1/15", op_a, lcd_req, lcd_code);
    end
    ack_lcd();
    m_mode = S_DONE;
    checks++;
    if (dbg_state !== S_DONE) begin errors++; $display("FAIL add_done got=%0d want=%0d", dbg_state, S_DONE); end
  endtask

  task automatic test_chain();
    bit g, e;
    press_key(KEY_MUL, g, e);
    press_key(4'd2, g, e);
    checks++;
    if ({op_a, op_b, math_sel} !== {16'h0046, 16'h0002, SEL_MUL}) begin
      errors++; $display("FAIL chain_operands got=%h/%h/%0d want=0046/0002/2", op_a, op_b, math_sel);
    end
    press_key(KEY_EQ, g, e);
    checks++;
    if (alu_start !== 1'b1) begin errors++; $display("FAIL chain_start got=%b want=1", alu_start); end
    run_alu(TO - 1, 16'h0092);
    model_result(92);
    checks++;
    if ({op_a, err, dbg_state} !== {16'h0092, 1'b0, S_SHOW}) begin
      errors++; $display("FAIL chain_late_done got=%h/%b/%0d want=0092/0/%0d", op_a, err, dbg_state, S_SHOW);
    end
    ack_lcd();
    m_mode = S_DONE;
  endtask

  task automatic test_div_zero();
    logic [3:0] keys[5] = '{KEY_CLR, 4'd9, KEY_DIV, 4'd0, KEY_EQ};
    bit g, e;
    int s0;
    s0 = start_cnt;
    foreach (keys[i]) press_key(keys[i], g, e);
    checks++;
    if ({err, dbg_state, g} !== {1'b1, S_ERR, 1'b1} || start_cnt != s0) begin
      errors++; $display("FAIL div0_err got=%b/%0d/%b starts=%0d want=1/%0d/1 starts=%0d",
        err, dbg_state, g, start_cnt, S_ERR, s0);
    end
    press_key(4'd5, g, e);
    checks++;
    if ({g, op_a, dbg_state} !== {1'b0, 16'h0009, S_ERR}) begin
      errors++; $display("FAIL div0_discard got=%b/%h/%0d want=0/0009/%0d", g, op_a, dbg_state, S_ERR);
    end
    press_key(KEY_CLR, g, e);
    checks++;
    if ({err, op_a, dbg_state, g} !== {1'b0, 16'h0000, S_A, 1'b1}) begin
      errors++; $display("FAIL div0_clear got=%b/%h/%0d/%b want=0/0000/%0d/1", err, op_a, dbg_state, g, S_A);
    end
  endtask

  task automatic test_overflow();
    bit g, e;
    press_key(KEY_CLR, g, e);
    for (int d = 1; d <= 5; d++) press_key(4'(d), g, e);
    checks++;
    if (op_a !== 16'h2345) begin errors++; $display("FAIL overflow got=%h want=2345", op_a); end
  endtask

  task automatic test_timeout();
    logic [3:0] keys[5] = '{KEY_CLR, 4'd1, KEY_ADD, 4'd2, KEY_EQ};
    bit g, e;
    foreach (keys[i]) press_key(keys[i], g, e);
    for (int k = 1; k <= TO; k++) begin
      @(posedge clk); #1;
      if (k < TO) begin
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL timeout_early k=%0d got=%b want=0", k, err); end
      end
    end
    model_timeout();
    checks++;
    if ({err, dbg_state, lcd_req, lcd_code} !== {1'b1, S_ERR, 1'b1, 4'd15}) begin
      errors++; $display("FAIL timeout_fire got=%b/%0d/%b/%0d want=1/%0d/1/15", err, dbg_state, lcd_req, lcd_code, S_ERR);
    end
    ack_lcd();
    press_key(KEY_CLR, g, e);
  endtask

  task automatic test_reset_mid();
    logic [3:0] keys[4] = '{4'd3, KEY_ADD, 4'd4, KEY_EQ};
    bit g, e;
    foreach (keys[i]) press_key(keys[i], g, e);
    @(posedge clk); #1;
    rst = 1'b1; @(posedge clk); #1;
    checks++;
    if ({key_ready, op_a, op_b, math_sel, alu_start, lcd_req, lcd_code, err, dbg_state} !==
        {1'b1, 16'h0, 16'h0, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0, S_A}) begin
      errors++; $display("FAIL rst_exec got=%h/%h/%b/%b/%0d want=0/0/0/0/%0d", op_a, op_b, alu_start, err, dbg_state, S_A);
    end
    rst = 1'b0; model_reset();
    run_alu(0, 16'h9999);
    checks++;
    if ({op_a, dbg_state, lcd_req} !== {16'h0000, S_A, 1'b0}) begin
      errors++; $display("FAIL late_done got=%h/%0d/%b want=0000/%0d/0", op_a, dbg_state, lcd_req, S_A);
    end
    key_valid = 1'b1; key_code = 4'd7;
    @(posedge clk); #1;
    key_valid = 1'b0; model_key(4'd7, e);
    checks++;
    if ({lcd_req, lcd_code} !== {1'b1, 4'd7}) begin
      errors++; $display("FAIL pend_lcd got=%b/%0d want=1/7", lcd_req, lcd_code);
    end
    rst = 1'b1; @(posedge clk); #1;
    checks++;
    if ({key_ready, op_a, lcd_req, lcd_code, err} !== {1'b1, 16'h0, 1'b0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL rst_lcd got=%b/%h/%b/%0d/%b want=1/0000/0/0/0", key_ready, op_a, lcd_req, lcd_code, err);
    end
    rst = 1'b0; model_reset();
  endtask

  task automatic test_random();
    bit g, e;
    int r, res;
    logic [3:0] code;
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 99) < 8) begin
        run_alu(0, 16'($urandom));
        checks++;
        if (op_a !== to_bcd(m_a)) begin errors++; $display("FAIL rnd_stray_done got=%h want=%h", op_a, to_bcd(m_a)); end
      end
      r = $urandom_range(0, 99);
      if (r < 55)      code = 4'($urandom_range(0, 9));
      else if (r < 75) code = 4'($urandom_range(10, 13));
      else if (r < 87) code = KEY_EQ;
      else if (r < 93) code = KEY_CLR;
      else             code = 4'($urandom_range(0, 15));
      press_key(code, g, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL rnd_lcd_req key=%0d got=%b want=%b", code, g, e); end
      if (m_mode == S_EXEC) begin
        checks++;
        if (alu_start !== 1'b1) begin errors++; $display("FAIL rnd_start got=%b want=1", alu_start); end
        res = $urandom_range(0, 9999);
        run_alu($urandom_range(0, TO - 1), to_bcd(res));
        model_result(res);
        checks++;
        if ({op_a, lcd_req} !== {to_bcd(m_a), 1'b1}) begin
          errors++; $display("FAIL rnd_result got=%h/%b want=%h/1", op_a, lcd_req, to_bcd(m_a));
        end
        ack_lcd();
        m_mode = S_DONE;
      end
      checks++;
      if ({op_a, op_b, math_sel, err, dbg_state} !== {to_bcd(m_a), to_bcd(m_b), 2'(m_sel), 1'(m_err), m_mode}) begin
        errors++; $display("FAIL rnd_state key=%0d got=%h/%h/%0d/%b/%0d want=%h/%h/%0d/%0d/%0d",
          code, op_a, op_b, math_sel, err, dbg_state, to_bcd(m_a), to_bcd(m_b), m_sel, m_err, m_mode);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_add();
    test_chain();
    test_div_zero();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL lcd_pending got=%0d want=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout got=running want=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
